// File: rtl/delay_pkg.sv
// ----------------------------------------------------------------------------
// delay_pkg
// Shared types and helpers for the runtime-programmable signed delay line.
//   delay_state_t : RUN  - output follows the buffer (or bypass for d=0)
//                   FILL - buffer history not yet valid, output forced to 0
//   clamp_delay   : limits a requested delay to the buffer depth
// ----------------------------------------------------------------------------
package delay_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        FILL = 1'b1
    } delay_state_t;

    // Requests above the buffer depth behave as the deepest delay.
    function automatic int clamp_delay(input int delay_sel, input int max_delay);
        return (delay_sel > max_delay) ? max_delay : delay_sel;
    endfunction

endpackage

// File: rtl/delay_ram_sdp.sv
// ----------------------------------------------------------------------------
// delay_ram_sdp
// DEPTH x WIDTH simple dual-port sample buffer. Write is synchronous; read is
// combinational so that the value returned on an edge that also writes the
// same address is the old (oldest) entry.
// Ports:
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (asynchronous)
// ----------------------------------------------------------------------------
module delay_ram_sdp #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic signed [WIDTH-1:0] wdata,
    input  logic [AW-1:0]           raddr,
    output logic signed [WIDTH-1:0] rdata
);

    logic signed [WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/delay_var_signed.sv
// ----------------------------------------------------------------------------
// delay_var_signed
// Signed delay line whose delay (in accepted samples) is set at runtime.
// Samples are stored in a circular buffer; the output is the sample accepted
// cur_delay accepted samples earlier. After reset or any delay change a fill
// phase forces c to 0 until the buffer holds cur_delay samples of history.
// Ports:
//   clk       : clock, posedge
//   rstn      : synchronous active-low reset
//   a_valid   : sample strobe, a is accepted on an edge with a_valid=1
//   a         : input sample (signed)
//   delay_sel : requested delay, clamped to MAX_DELAY
//   c         : delayed sample, registered
//   c_valid   : one-cycle pulse marking an update of c
//   busy      : high while filling (c forced to 0)
// ----------------------------------------------------------------------------
module delay_var_signed
    import delay_pkg::*;
#(
    parameter int MAX_DELAY = 16,
    parameter int WIDTH     = 16
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             a_valid,
    input  logic signed [WIDTH-1:0]          a,
    input  logic [$clog2(MAX_DELAY+1)-1:0]   delay_sel,
    output logic signed [WIDTH-1:0]          c,
    output logic                             c_valid,
    output logic                             busy
);

    localparam int DW = $clog2(MAX_DELAY + 1);
    localparam int PW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

    delay_state_t            state_reg, state_next;
    logic [PW-1:0]           wr_ptr_reg, wr_ptr_next;
    logic [DW-1:0]           cur_delay_reg, cur_delay_next;
    logic [DW-1:0]           fill_cnt_reg, fill_cnt_next;
    logic signed [WIDTH-1:0] c_reg, c_next;
    logic                    c_valid_reg, c_valid_next;

    logic [DW-1:0]           d_new;
    logic                    change;
    logic [DW-1:0]           fill_inc;
    logic [PW-1:0]           rd_addr;
    logic signed [WIDTH-1:0] rd_data;
    logic                    ram_we;
    int                      rd_i;

    delay_ram_sdp #(
        .DEPTH (MAX_DELAY),
        .WIDTH (WIDTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_reg),
        .wdata (a),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // When no change is detected d_new equals cur_delay, so d_new is always
    // the effective delay for this edge.
    always_comb begin
        d_new  = DW'(clamp_delay(int'(delay_sel), MAX_DELAY));
        change = (d_new != cur_delay_reg);

        // Counting restarts from zero on the edge where a change is seen.
        fill_inc = (change ? '0 : fill_cnt_reg) + DW'(1);

        // Slot written d accepted samples ago; d=MAX_DELAY lands on wr_ptr.
        rd_i = int'(wr_ptr_reg) + MAX_DELAY - int'(d_new);
        if (rd_i >= MAX_DELAY) begin
            rd_i = rd_i - MAX_DELAY;
        end
        rd_addr = PW'(rd_i);
    end

    always_comb begin
        state_next     = state_reg;
        wr_ptr_next    = wr_ptr_reg;
        cur_delay_next = cur_delay_reg;
        fill_cnt_next  = fill_cnt_reg;
        c_next         = c_reg;
        c_valid_next   = 1'b0;
        ram_we         = 1'b0;

        if (change) begin
            cur_delay_next = d_new;
            fill_cnt_next  = '0;
            state_next     = (d_new != '0) ? FILL : RUN;
        end

        if (a_valid && rstn) begin
            ram_we       = 1'b1;
            c_valid_next = 1'b1;
            wr_ptr_next  = (wr_ptr_reg == PW'(MAX_DELAY - 1)) ? '0 : wr_ptr_reg + PW'(1);

            if (d_new == '0) begin
                c_next = a;
            end else if ((state_reg == RUN) && !change) begin
                c_next = rd_data;
            end else begin
                c_next        = '0;
                fill_cnt_next = fill_inc;
                if (fill_inc == d_new) begin
                    state_next = RUN;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= RUN;
            wr_ptr_reg    <= '0;
            cur_delay_reg <= '0;
            fill_cnt_reg  <= '0;
            c_reg         <= '0;
            c_valid_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            cur_delay_reg <= cur_delay_next;
            fill_cnt_reg  <= fill_cnt_next;
            c_reg         <= c_next;
            c_valid_reg   <= c_valid_next;
        end
    end

    assign c       = c_reg;
    assign c_valid = c_valid_reg;
    assign busy    = (state_reg == FILL);

endmodule

// File: tb/tb_delay_var_signed.sv
// ----------------------------------------------------------------------------
// tb_delay_var_signed
// Directed scenarios with literal expectations plus a randomized run, all
// compared against a queue-based model of the delay line after every edge.
// ----------------------------------------------------------------------------
module tb_delay_var_signed;

    localparam int MAX_DELAY = 16;
    localparam int WIDTH     = 16;
    localparam int DW        = $clog2(MAX_DELAY + 1);

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic                    a_valid = 1'b0;
    logic signed [WIDTH-1:0] a = '0;
    logic [DW-1:0]           delay_sel = '0;
    logic signed [WIDTH-1:0] c;
    logic                    c_valid;
    logic                    busy;

    int total = 0;
    int bad   = 0;

    delay_var_signed #(
        .MAX_DELAY (MAX_DELAY),
        .WIDTH     (WIDTH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .a_valid   (a_valid),
        .a         (a),
        .delay_sel (delay_sel),
        .c         (c),
        .c_valid   (c_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Model: history of every accepted sample since reset, the active delay
    // and how many zero outputs are still owed before history is valid.
    int m_cur  = 0;
    int m_fill = 0;
    int m_c    = 0;
    bit m_cv   = 1'b0;
    bit m_busy = 1'b0;
    int hist[$];

    always @(posedge clk) begin
        int dn;
        if (!rstn) begin
            m_cur  = 0;
            m_fill = 0;
            m_c    = 0;
            m_cv   = 1'b0;
            hist.delete();
        end else begin
            dn = int'(delay_sel);
            if (dn > MAX_DELAY) dn = MAX_DELAY;
            if (dn != m_cur) begin
                m_cur  = dn;
                m_fill = dn;
            end
            if (a_valid) begin
                if (m_cur == 0) begin
                    m_c = int'(a);
                end else if (m_fill > 0) begin
                    m_c    = 0;
                    m_fill = m_fill - 1;
                end else if (hist.size() >= m_cur) begin
                    m_c = hist[hist.size() - m_cur];
                end else begin
                    m_c = 99999;
                end
                hist.push_back(int'(a));
                if (hist.size() > 64) void'(hist.pop_front());
                m_cv = 1'b1;
            end else begin
                m_cv = 1'b0;
            end
        end
        m_busy = (m_fill > 0);
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one clock of stimulus, then compare all outputs with the model.
    task automatic cycle(input bit v, input int av, input int sel);
        a_valid   = v;
        a         = WIDTH'(av);
        delay_sel = DW'(sel);
        @(posedge clk);
        #1;
        $display("t=%0t rstn=%0b v=%0b a=%0d sel=%0d -> c=%0d c_valid=%0b busy=%0b",
                 $time, rstn, v, av, sel, c, c_valid, busy);
        check("model_c", int'(c), m_c);
        check("model_c_valid", int'(c_valid), int'(m_cv));
        check("model_busy", int'(busy), int'(m_busy));
    endtask

    task automatic do_reset(input int sel);
        rstn = 1'b0;
        cycle(1'b0, 0, sel);
        rstn = 1'b1;
    endtask

    initial begin
        int t1_exp[8]   = '{0, 0, 0, 1, 2, 3, 4, 5};
        int t1_busy[8]  = '{1, 1, 0, 0, 0, 0, 0, 0};
        bit t2_v[6]     = '{1, 0, 0, 1, 1, 1};
        int t2_a[6]     = '{-5, 0, 0, 7, 9, 11};
        int t2_c[6]     = '{0, 0, 0, 0, -5, 7};
        int t2_busy[6]  = '{1, 1, 1, 0, 0, 0};
        int sel;

        // Reset state
        do_reset(3);
        check("rst_c", int'(c), 0);
        check("rst_c_valid", int'(c_valid), 0);
        check("rst_busy", int'(busy), 0);

        // d=3 from reset, continuous samples 1..8
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, i + 1, 3);
            check("t1_c", int'(c), t1_exp[i]);
            check("t1_busy", int'(busy), t1_busy[i]);
            check("t1_c_valid", int'(c_valid), 1);
        end

        // d=2 with a gap in a_valid
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            cycle(t2_v[i], t2_a[i], 2);
            check("t2_c", int'(c), t2_c[i]);
            check("t2_c_valid", int'(c_valid), int'(t2_v[i]));
            check("t2_busy", int'(busy), t2_busy[i]);
        end

        // Running at d=4, then switch to d=1
        do_reset(4);
        for (int i = 1; i <= 8; i++) cycle(1'b1, i, 4);
        check("t3_c_before", int'(c), 4);
        cycle(1'b1, 100, 1);
        check("t3_c_zero", int'(c), 0);
        cycle(1'b1, 101, 1);
        check("t3_c_prev", int'(c), 100);

        // Bypass, then clamped delay 20 -> 16 with pointer wrap
        do_reset(0);
        cycle(1'b1, 10, 0);
        check("t4_bypass", int'(c), 10);
        cycle(1'b1, -20, 0);
        check("t4_bypass_neg", int'(c), -20);
        check("t4_busy", int'(busy), 0);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1000 + i, 20);
            if (i == 0)  check("t4_busy_rise", int'(busy), 1);
            if (i == 15) check("t4_busy_fall", int'(busy), 0);
            if (i == 16) check("t4_c_first", int'(c), 1000);
            if (i == 39) check("t4_c_last", int'(c), 1023);
        end

        // Reset mid-fill at d=5
        do_reset(5);
        cycle(1'b1, 1, 5);
        cycle(1'b1, 2, 5);
        check("t5_busy_mid", int'(busy), 1);
        do_reset(5);
        check("t5_rst_c", int'(c), 0);
        check("t5_rst_cv", int'(c_valid), 0);
        check("t5_rst_busy", int'(busy), 0);
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 11 + i, 5);
            if (i < 5) check("t5_fill_c", int'(c), 0);
        end
        check("t5_c_hist", int'(c), 12);

        // Signed extremes at d=1
        do_reset(1);
        cycle(1'b1, -32768, 1);
        check("t6_c0", int'(c), 0);
        cycle(1'b1, 32767, 1);
        check("t6_min", int'(c), -32768);
        cycle(1'b1, 0, 1);
        check("t6_max", int'(c), 32767);

        // Randomized run
        sel = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) sel = int'($urandom_range(0, 31));
            if ($urandom_range(0, 299) == 0) begin
                do_reset(sel);
            end else begin
                cycle($urandom_range(0, 9) < 7, int'($urandom_range(0, 65535)) - 32768, sel);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
